// File: rtl/decoder_pkg.sv
// Shared definitions for the sequential 3-to-8 decoder.
//   state_e : FSM state encoding (IDLE, HOLD, GAP)
//   IDX_W   : width of the encoded index
//   N_LINES : number of one-hot output lines
package decoder_pkg;

    localparam int IDX_W   = 3;
    localparam int N_LINES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_3x8_hold_if.sv
// Handshake/bus bundle between an index source and decoder_3x8_hold.
// Handshake: an index on a is transferred at a rising clk edge when
// valid && ready && !abort; a and valid are ignored in every other cycle
// and a dropped valid is never queued.
//   a     : encoded index              (master -> slave)
//   valid : a is valid this cycle      (master -> slave)
//   abort : cancel current hold/gap    (master -> slave)
//   ready : slave can accept           (slave -> master)
//   y     : one-hot decoded output     (slave -> master)
//   busy  : slave not idle             (slave -> master)
//   done  : last hold cycle pulse      (slave -> master)
interface decoder_3x8_hold_if;
    import decoder_pkg::*;

    logic [IDX_W-1:0]   a;
    logic               valid;
    logic               abort;
    logic               ready;
    logic [N_LINES-1:0] y;
    logic               busy;
    logic               done;

    modport master (
        output a, valid, abort,
        input  ready, y, busy, done
    );

    modport slave (
        input  a, valid, abort,
        output ready, y, busy, done
    );

endinterface

// File: rtl/decoder_3x8.sv
// Purely combinational 3-to-8 decoder with enable.
//   in_i  : encoded index
//   en_i  : enable; out_o is all zero when low
//   out_o : one-hot line selected by in_i
module decoder_3x8
    import decoder_pkg::*;
(
    input  logic [IDX_W-1:0]   in_i,
    input  logic               en_i,
    output logic [N_LINES-1:0] out_o
);

    always_comb begin
        out_o = '0;
        if (en_i) begin
            out_o = N_LINES'(1) << in_i;
        end
    end

endmodule

// File: rtl/decoder_3x8_hold.sv
// Sequential 3-to-8 decoder: accepts an index over a valid/ready handshake,
// drives the matching one-hot line for HOLD_CYCLES cycles, then forces
// GAP_CYCLES idle cycles before the next accept.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   bus         : slave side of decoder_3x8_hold_if (a/valid/abort in,
//                 ready/y/busy/done out)
//   dbg_state_o : current FSM state
module decoder_3x8_hold
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_3x8_hold_if.slave    bus,
    output state_e               dbg_state_o
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("decoder_3x8_hold: HOLD_CYCLES must be 1..255");
    end
    if (GAP_CYCLES > 255) begin : g_bad_gap
        $error("decoder_3x8_hold: GAP_CYCLES must be 0..255");
    end

    // Counter reload values; the GAP reload is only used when GAP_CYCLES>0.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam bit         HAS_GAP   = (GAP_CYCLES > 0);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else if (bus.abort) begin
            // Abort wins over everything, including an accept in IDLE.
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid) begin
                        idx_q   <= bus.a;
                        cnt_q   <= HOLD_LOAD;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q == 8'd0) begin
                        if (HAS_GAP) begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // All outputs decode registered state only, so async reset clears y
    // immediately and nothing flows combinationally from a/valid/abort.
    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == HOLD) && (cnt_q == 8'd0);
    assign dbg_state_o = state_q;

    decoder_3x8 u_dec (
        .in_i  (idx_q),
        .en_i  (state_q == HOLD),
        .out_o (bus.y)
    );

endmodule

// File: tb/tb_decoder_3x8_hold.sv
module tb_decoder_3x8_hold;
    import decoder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic rst_n0;
    always #5 clk = ~clk;

    decoder_3x8_hold_if bus ();
    decoder_3x8_hold_if bus0 ();
    state_e dbg_state;
    state_e dbg_state0;

    decoder_3x8_hold #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    decoder_3x8_hold #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n0),
        .bus         (bus0),
        .dbg_state_o (dbg_state0)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at that same point, so they reflect the state after that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(bus.ready), 32'd1);
    endtask

    task automatic issue(input logic [2:0] idx);
        bus.a     = idx;
        bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] e;
        bus.a = 3'd0; bus.valid = 1'b0; bus.abort = 1'b0;
        bus0.a = 3'd0; bus0.valid = 1'b0; bus0.abort = 1'b0;
        rst_n = 1'b0; rst_n0 = 1'b0;

        // 1: reset held with valid=1, a=7
        bus.valid = 1'b1; bus.a = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_y",     32'(bus.y),     32'h00);
            check("rst_busy",  32'(bus.busy),  32'd0);
            check("rst_done",  32'(bus.done),  32'd0);
            check("rst_ready", 32'(bus.ready), 32'd1);
        end
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        bus.valid = 1'b0;
        rst_n = 1'b1; rst_n0 = 1'b1;
        tick();
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_y",    32'(bus.y),    32'h00);

        // 2: single accept of a=5
        issue(3'd5);
        for (int t = 1; t <= 4; t++) begin
            check("t2_y",    32'(bus.y),    32'h20);
            check("t2_done", 32'(bus.done), (t == 4) ? 32'd1 : 32'd0);
            if (t < 4) tick();
        end
        tick();
        check("t2_gap_y",     32'(bus.y),     32'h00);
        check("t2_gap_ready", 32'(bus.ready), 32'd0);
        tick();
        check("t2_idle_ready", 32'(bus.ready), 32'd1);

        // 3: sweep all codes through the expected queue
        for (int i = 0; i < 8; i++) begin
            wait_ready();
            issue(3'(i));
            e = 8'h01 << i;
            for (int k = 0; k < 4; k++) exp_q.push_back(e);
            for (int k = 0; k < 4; k++) begin
                check("sweep_y", 32'(bus.y), 32'(exp_q.pop_front()));
                check("sweep_onehot", 32'($countones(bus.y)), 32'd1);
                if (k < 3) tick();
            end
            tick();
            check("sweep_gap_y", 32'(bus.y), 32'h00);
        end

        // 4: valid held during HOLD/GAP is ignored until IDLE
        wait_ready();
        bus.a = 3'd2; bus.valid = 1'b1;
        tick();
        bus.a = 3'd6;
        for (int k = 0; k < 4; k++) begin
            check("t4_hold_y", 32'(bus.y), 32'h04);
            tick();
        end
        check("t4_gap_y", 32'(bus.y), 32'h00);
        tick();
        check("t4_idle_ready", 32'(bus.ready), 32'd1);
        tick();
        bus.valid = 1'b0;
        check("t4_second_y", 32'(bus.y), 32'h40);
        wait_ready();

        // 5: abort mid-hold, abort with valid in IDLE, abort on last hold cycle
        issue(3'd1);
        check("t5_y_t1", 32'(bus.y), 32'h02);
        tick();
        check("t5_y_t2", 32'(bus.y), 32'h02);
        bus.abort = 1'b1;
        tick();
        check("t5_abort_y",    32'(bus.y),    32'h00);
        check("t5_abort_busy", 32'(bus.busy), 32'd0);
        check("t5_abort_done", 32'(bus.done), 32'd0);
        bus.valid = 1'b1; bus.a = 3'd4;
        tick();
        bus.valid = 1'b0; bus.abort = 1'b0;
        check("t5_noacc_busy", 32'(bus.busy), 32'd0);
        check("t5_noacc_y",    32'(bus.y),    32'h00);
        tick();
        check("t5_noacc_y2", 32'(bus.y), 32'h00);
        issue(3'd0);
        tick(); tick(); tick();
        check("t5_last_done", 32'(bus.done), 32'd1);
        check("t5_last_y",    32'(bus.y),    32'h01);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_last_ready", 32'(bus.ready), 32'd1);
        check("t5_last_y0",    32'(bus.y),     32'h00);

        // 6: GAP_CYCLES=0 back-to-back grants, then async reset mid-hold
        bus0.a = 3'd3; bus0.valid = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            check("t6_period_y", 32'(bus0.y), ((k % 5) < 4) ? 32'h08 : 32'h00);
            tick();
        end
        check("t6_pre_rst_y", 32'(bus0.y), 32'h08);
        #2;
        rst_n0 = 1'b0;
        #1;
        check("t6_async_y",    32'(bus0.y),    32'h00);
        check("t6_async_busy", 32'(bus0.busy), 32'd0);
        bus0.valid = 1'b0;
        tick();
        rst_n0 = 1'b1;
        tick();
        check("t6_after_y", 32'(bus0.y), 32'h00);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_3x8_hold.md
Name: decoder_3x8_hold

Overview:
- Sequential 3-to-8 decoder: the return path for the 8-to-3 priority encoder.
- Accepts an encoded index with a valid/ready handshake.
- Drives the matching one-hot line for a fixed number of cycles, then inserts an optional idle gap before the next accept.
- Sits downstream of the encoder to turn a winning request index back into a timed one-hot grant/select.

Parameters:
- HOLD_CYCLES, 4, cycles y stays one-hot per accepted index (legal range 1..255).
- GAP_CYCLES, 1, forced idle cycles after each hold, y=0 and ready=0 (legal range 0..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  3  encoded index; all 8 codes legal.
- valid  input  1  a is valid this cycle.
- ready  output  1  block can accept an index this cycle.
- abort  input  1  synchronous cancel of the current hold or gap.
- y  output  8  one-hot decoded output; 8'h00 when not holding.
- busy  output  1  state != IDLE.
- done  output  1  single-cycle pulse in the last HOLD cycle.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, async):
  - state=IDLE, idx_q=0, cnt=0.
  - y=8'h00, done=0, busy=0, ready=1.
  - Inputs are ignored while rst_n is low.
- States: IDLE, HOLD, GAP. The state register and an 8-bit down-counter cnt are the only sequential elements besides idx_q.
- Outputs:
  - All outputs are decoded from registers only; there is no combinational path from a, valid or abort.
  - ready = (state==IDLE).
  - y = (state==HOLD) ? (8'h01 << idx_q) : 8'h00.
  - done = (state==HOLD && cnt==0).
- Accept: valid && ready && !abort at a rising edge.
  - idx_q <= a; cnt <= HOLD_CYCLES-1; state <= HOLD.
  - Latency is 1 cycle: y is one-hot in the cycle after accept.
- HOLD:
  - cnt decrements each cycle.
  - When cnt==0: GAP_CYCLES>0 -> state <= GAP, cnt <= GAP_CYCLES-1; GAP_CYCLES==0 -> state <= IDLE.
  - y is one-hot for exactly HOLD_CYCLES cycles.
- GAP:
  - y=0, ready=0.
  - cnt decrements; when cnt==0 -> state <= IDLE.
- a/valid while ready=0: ignored; a is sampled only at accept. There is no queueing, so a valid dropped by the source is lost by design.
- abort (highest priority after reset):
  - From any state -> IDLE at the next edge; cnt <= 0.
  - No done pulse: if abort coincides with the last HOLD cycle, done is still visible that cycle (it is decoded from current state), but no further output follows.
  - abort && valid in IDLE: no accept.
- Back-to-back with GAP_CYCLES=0: at least one y=0 cycle (the IDLE accept cycle) separates consecutive grants.
- Async reset mid-HOLD/GAP: y drops to 8'h00 immediately, without waiting for clk; the transaction is discarded.
- Width rules:
  - cnt is 8 bits.
  - HOLD_CYCLES-1 and GAP_CYCLES-1 are computed at elaboration; GAP_CYCLES==0 never loads cnt for GAP.
  - Parameter out of range: elaboration-time error.

Decomposition:
- Shared package decoder_pkg:
  - state encoding (IDLE=2'd0, HOLD=2'd1, GAP=2'd2);
  - index width constant IDX_W=3;
  - line count N_LINES=8.
- Sub-module: decoder_3x8, purely combinational (in 3, en 1 -> out 8 one-hot; out=0 when en=0).
  - Instantiated with in=idx_q, en=(state==HOLD).
  - Also reusable as the encoder's check model in benches.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=1 unless noted):
1. Hold rst_n low 3 cycles with valid=1, a=3'd7 -> y=8'h00, busy=0, done=0, ready=1 throughout; no accept after release unless valid is sampled high post-release.
2. a=3'd5, valid=1 for one cycle at T0 -> y=8'h20 at T1..T4; done=1 only at T4; y=8'h00, ready=0 at T5; ready=1 at T6.
3. Sweep a=0..7, each issued at the first ready cycle -> y=8'h01,02,04,08,10,20,40,80, each exactly 4 cycles, never two bits set.
4. Accept a=3'd2, then hold valid=1 with a=3'd6 during HOLD/GAP -> y stays 8'h04 for 4 cycles; a=3'd6 is accepted only at the next IDLE cycle, giving y=8'h40.
5. Accept a=3'd1 at T0, abort=1 at T2 -> y=8'h02 at T1..T2, y=8'h00 and busy=0 at T3, no done. Then abort=1 with valid=1 in IDLE -> no accept.
6. GAP_CYCLES=0 with valid held high, a=3'd3 -> grants repeat with period 5: four cycles of 8'h08 then one 8'h00. Asserting rst_n low mid-HOLD -> y=8'h00 in the same cycle, before the next clk edge.
